bcd_add_seq: RTL and testbench

- Digit-serial sequencer for the shared single-digit decimal adder.
- Accepts two DIGITS-wide packed BCD operands on a start pulse.
- Feeds the adder one digit per clock, LSD first, ripples the decimal carry through a register, and collects the sum digits.
- Result registers feed the scan controller / 14-segment display path directly. Handshake: start / busy / done.

---
 rtl/bcd_add_seq_if.sv | 25 ++
 rtl/bcd_add_seq.sv | 159 +++++++++++++++
 tb/tb_bcd_add_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_add_seq_if.sv
// Operand/result handshake bundle for the digit-serial BCD add sequencer.
// master = requester (drives operands and start), slave = sequencer.
interface bcd_add_seq_if #(
   parameter int DIGITS = 2
);
   logic                  start;
   logic [4*DIGITS-1:0]   a_bcd;
   logic [4*DIGITS-1:0]   b_bcd;
   logic                  cin;
   logic [4*DIGITS-1:0]   sum_bcd;
   logic                  cout;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, a_bcd, b_bcd, cin,
      input  sum_bcd, cout, busy, done, err
   );

   modport slave (
      input  start, a_bcd, b_bcd, cin,
      output sum_bcd, cout, busy, done, err
   );
endinterface

// File: rtl/bcd_add_seq.sv
// Digit-serial sequencer driving a shared single-digit decimal adder, LSD first.
// Optional invalid-digit check is built only when BCD_ADD_SEQ_CHECK_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start; result registers hold last answer
// S_ADD  | one digit per clock through the shared adder
// S_DONE | one-cycle completion pulse, results stable
module bcd_add_seq #(
   parameter int DIGITS = 2
) (
   input  logic          clk,
   input  logic          rst,
   bcd_add_seq_if.slave  bus,
   output logic [3:0]    add_a,
   output logic [3:0]    add_b,
   output logic          add_cin,
   input  logic [3:0]    add_s,
   input  logic          add_cout
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic               carry;
   logic [IDX_W-1:0]   idx;
   logic               last_dig;
   logic [3:0]         dig_a;
   logic [3:0]         dig_b;
   logic               start_bad;
   logic [W-1:0]       sum_reg;
   logic               cout_reg;
   logic               err_reg;
   logic               busy_c;
   logic               done_c;

   always_comb begin
      dig_a = 4'd0;
      dig_b = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            dig_a = a_reg[4*i +: 4];
            dig_b = b_reg[4*i +: 4];
         end
      end
   end

   assign last_dig = (idx == IDX_W'(DIGITS - 1));

`ifdef BCD_ADD_SEQ_CHECK_EN
   always_comb begin
      start_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((bus.a_bcd[4*i +: 4] > 4'd9) || (bus.b_bcd[4*i +: 4] > 4'd9))
            start_bad = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_reg <= 1'b0;
      else if ((state == S_IDLE) && bus.start)
         err_reg <= start_bad;
   end
`else
   assign start_bad = 1'b0;
   assign err_reg   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      add_a     = 4'd0;
      add_b     = 4'd0;
      add_cin   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start)
               state_nxt = start_bad ? S_DONE : S_ADD;
         end
         S_ADD: begin
            busy_c  = 1'b1;
            add_a   = dig_a;
            add_b   = dig_b;
            add_cin = carry;
            if (last_dig)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            busy_c    = 1'b1;
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // add_s is captured on the same edge that advances idx; no pipelining of the adder
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_reg <= bus.a_bcd;
                  b_reg <= bus.b_bcd;
                  carry <= bus.cin;
                  idx   <= '0;
                  if (start_bad) begin
                     sum_reg  <= '0;
                     cout_reg <= 1'b0;
                  end
               end
            end
            S_ADD: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx == IDX_W'(i))
                     sum_reg[4*i +: 4] <= add_s;
               end
               carry <= add_cout;
               idx   <= idx + 1'b1;
               if (last_dig)
                  cout_reg <= add_cout;
            end
            default: ;
         endcase
      end
   end

   assign bus.sum_bcd = sum_reg;
   assign bus.cout    = cout_reg;
   assign bus.err     = err_reg;
   assign bus.busy    = busy_c;
   assign bus.done    = done_c;

endmodule

// File: tb/tb_bcd_add_seq.sv
// Scoreboard bench for bcd_add_seq (DIGITS=2) with a behavioural decimal adder on add_*.
module tb_bcd_add_seq;

   logic       clk;
   logic       rst;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_cin;
   logic [3:0] add_s;
   logic       add_cout;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       err;
   } exp_t;

   exp_t exp_q[$];

   bcd_add_seq_if #(.DIGITS(2)) bus ();

   bcd_add_seq #(.DIGITS(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_s    (add_s),
      .add_cout (add_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      logic [4:0] t;
      t = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
      if (t > 5'd9) begin
         add_cout = 1'b1;
         add_s    = 4'(t - 5'd10);
      end else begin
         add_cout = 1'b0;
         add_s    = t[3:0];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 expected=0");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum_bcd", {24'd0, bus.sum_bcd}, {24'd0, e.sum});
            chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
            chk("err", {31'd0, bus.err}, {31'd0, e.err});
         end
      end
   end

   // called at a negedge; returns at the negedge after the start edge
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
      bus.a_bcd = a;
      bus.b_bcd = b;
      bus.cin   = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a_bcd = 8'h77;
      bus.b_bcd = 8'h66;
      bus.cin   = 1'b1;
   endtask

   task automatic push(input logic [7:0] s, input logic c, input logic e);
      exp_t x;
      x.sum  = s;
      x.cout = c;
      x.err  = e;
      exp_q.push_back(x);
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL wait_idle_timeout actual=pending%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int busy_cnt;
      int done_at;
      bit seen;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a_bcd = 8'h00;
      bus.b_bcd = 8'h00;
      bus.cin   = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_sum", {24'd0, bus.sum_bcd}, 32'h0);
      chk("rst_cout", {31'd0, bus.cout}, 32'h0);
      chk("rst_busy", {31'd0, bus.busy}, 32'h0);
      chk("rst_done", {31'd0, bus.done}, 32'h0);
      chk("rst_err", {31'd0, bus.err}, 32'h0);
      chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // 47 + 38: digit feed, busy length and done position
      push(8'h85, 1'b0, 1'b0);
      issue(8'h47, 8'h38, 1'b0);
      chk("feed0", {23'd0, add_a, add_b, add_cin}, {23'd0, 4'd7, 4'd8, 1'b0});
      busy_cnt = 1;
      done_at  = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0)
            chk("feed1", {23'd0, add_a, add_b, add_cin}, {23'd0, 4'd4, 4'd3, 1'b1});
         if (bus.busy) begin
            busy_cnt++;
            if (bus.done) done_at = busy_cnt;
         end
      end
      chk("busy_cycles", busy_cnt, 32'd3);
      chk("done_cycle", done_at, 32'd3);
      wait_idle(10);

      push(8'h00, 1'b1, 1'b0);
      issue(8'h99, 8'h01, 1'b0);
      wait_idle(10);

      push(8'h99, 1'b1, 1'b0);
      issue(8'h99, 8'h99, 1'b1);
      wait_idle(10);

      push(8'h01, 1'b0, 1'b0);
      issue(8'h00, 8'h00, 1'b1);
      chk("cin_feed0", {23'd0, add_a, add_b, add_cin}, {23'd0, 4'd0, 4'd0, 1'b1});
      @(negedge clk);
      chk("cin_feed1", {23'd0, add_a, add_b, add_cin}, {23'd0, 4'd0, 4'd0, 1'b0});
      wait_idle(10);

      // start while busy is ignored
      push(8'h46, 1'b0, 1'b0);
      issue(8'h12, 8'h34, 1'b0);
      issue(8'h50, 8'h50, 1'b0);
      wait_idle(10);
      repeat (4) @(negedge clk);

      // back-to-back: start held from the DONE cycle into the following IDLE cycle
      push(8'h68, 1'b0, 1'b0);
      issue(8'h23, 8'h45, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("b2b_done_seen", {31'd0, seen}, 32'd1);
      push(8'h25, 1'b1, 1'b0);
      bus.a_bcd = 8'h58;
      bus.b_bcd = 8'h67;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_accepted", {31'd0, bus.busy}, 32'd1);
      wait_idle(10);

      // reset during ADD aborts with no done
      issue(8'h55, 8'h44, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_sum", {24'd0, bus.sum_bcd}, 32'h0);
      chk("abort_cout", {31'd0, bus.cout}, 32'h0);
      chk("abort_busy", {31'd0, bus.busy}, 32'h0);
      chk("abort_done", {31'd0, bus.done}, 32'h0);
      chk("abort_add", {23'd0, add_a, add_b, add_cin}, 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      push(8'h42, 1'b0, 1'b0);
      issue(8'h25, 8'h17, 1'b0);
      wait_idle(10);

`ifdef BCD_ADD_SEQ_CHECK_EN
      push(8'h00, 1'b0, 1'b1);
      issue(8'h3A, 8'h01, 1'b0);
      chk("chk_done_early", {31'd0, bus.done}, 32'd1);
      wait_idle(10);

      push(8'h30, 1'b0, 1'b0);
      issue(8'h10, 8'h20, 1'b0);
      wait_idle(10);
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
